// File: rtl/dtc_slow_ctrl.sv
// DTC slow-control sequencer: queues slow commands, runs them on the
// register bus with an ack timeout, and returns read/timeout responses.
module dtc_slow_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        dtc_clk_90,
    input  logic        rst_n,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_data,
    input  logic        cmd_write,
    input  logic        cmd_read,
    input  logic        rstcmd,
    output logic [30:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [30:0] rsp_addr,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        overflow,
    output logic [4:0]  fifo_level
);

    localparam int          PW   = $clog2(FIFO_DEPTH);
    localparam logic [15:0] TO   = 16'(TIMEOUT);
    localparam logic [4:0]  FULL = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state;
    state_t          state_d;
    logic [63:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      count;
    logic [15:0]     cnt;
    logic [63:0]     head;
    logic            push_req;
    logic            push_ok;
    logic            full;
    logic            pop;
    logic            ack_done;
    logic            timed_out;
    logic            rsp_done;

    assign push_req   = cmd_write | cmd_read;
    assign full       = (count == FULL);
    assign push_ok    = push_req && !rstcmd && (!full || pop);
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE) || (count != 5'd0);
    assign fifo_level = count;

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        ack_done  = 1'b0;
        timed_out = 1'b0;
        rsp_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != 5'd0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (reg_ack) begin
                    ack_done = 1'b1;
                    state_d  = reg_re ? RESP : IDLE;
                end else if (cnt == TO) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush overrides anything the FSM wanted to do this cycle
        if (rstcmd) begin
            state_d   = IDLE;
            pop       = 1'b0;
            ack_done  = 1'b0;
            timed_out = 1'b0;
            rsp_done  = 1'b0;
        end
    end

    always_ff @(posedge dtc_clk_90) begin
        if (push_ok)
            mem[wr_ptr] <= {cmd_read | cmd_address[31],
                            cmd_address[30:0], cmd_data};
    end

    always_ff @(posedge dtc_clk_90 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 5'd0;
            cnt       <= 16'd0;
            overflow  <= 1'b0;
            reg_addr  <= 31'd0;
            reg_wdata <= 32'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= 31'd0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            if (rstcmd) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= 5'd0;
                cnt       <= 16'd0;
                overflow  <= 1'b0;
                reg_we    <= 1'b0;
                reg_re    <= 1'b0;
                rsp_valid <= 1'b0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push_ok && !pop)
                    count <= count + 5'd1;
                else if (!push_ok && pop)
                    count <= count - 5'd1;
                if (push_req && !push_ok)
                    overflow <= 1'b1;
                if (pop) begin
                    reg_addr  <= head[62:32];
                    reg_wdata <= head[31:0];
                    reg_re    <= head[63];
                    reg_we    <= !head[63];
                    cnt       <= 16'd0;
                end else if (state == ISSUE) begin
                    cnt <= cnt + 16'd1;
                end
                if (ack_done || timed_out) begin
                    reg_we <= 1'b0;
                    reg_re <= 1'b0;
                end
                if (ack_done && reg_re) begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= reg_addr;
                    rsp_data  <= reg_rdata;
                    rsp_err   <= 1'b0;
                end
                if (timed_out) begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= reg_addr;
                    rsp_data  <= 32'd0;
                    rsp_err   <= 1'b1;
                end
                if (rsp_done)
                    rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dtc_slow_ctrl.sv
// Directed bench for dtc_slow_ctrl: write, read, timeout, overflow,
// flush and asynchronous reset scenarios with hand-computed expectations.
module tb_dtc_slow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic        cmd_write;
    logic        cmd_read;
    logic        rstcmd;
    logic [30:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [30:0] rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        overflow;
    logic [4:0]  fifo_level;

    int n_cmp = 0;
    int n_err = 0;

    dtc_slow_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .dtc_clk_90  (clk),
        .rst_n       (rst_n),
        .cmd_address (cmd_address),
        .cmd_data    (cmd_data),
        .cmd_write   (cmd_write),
        .cmd_read    (cmd_read),
        .rstcmd      (rstcmd),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_ack     (reg_ack),
        .reg_rdata   (reg_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_address = 0; cmd_data = 0;
        cmd_write = 0; cmd_read = 0; rstcmd = 0;
        reg_ack = 0; reg_rdata = 0; rsp_ready = 0;
        tick();
        cmd_write = 1'b1; cmd_address = 32'h0000_0099;
        tick();
        n_cmp++;
        if ({reg_we, reg_re, rsp_valid, busy, overflow} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b required 00000",
                     {reg_we, reg_re, rsp_valid, busy, overflow});
        end
        n_cmp++;
        if (fifo_level !== 5'd0 || reg_addr !== 31'd0) begin
            n_err++;
            $display("FAIL reset_level: level %0d addr %h required 0 0",
                     fifo_level, reg_addr);
        end
        cmd_write = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || fifo_level !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy %b level %0d required 0 0",
                     busy, fifo_level);
        end
    endtask

    task automatic test_write();
        cmd_address = 32'h0000_0010; cmd_data = 32'hCAFE_F00D;
        cmd_write = 1'b1;
        tick();
        cmd_write = 1'b0;
        n_cmp++;
        if (reg_we !== 1'b0 || fifo_level !== 5'd1) begin
            n_err++;
            $display("FAIL wr_queued: we %b level %0d required 0 1",
                     reg_we, fifo_level);
        end
        tick();
        n_cmp++;
        if (reg_we !== 1'b1 || reg_re !== 1'b0 || reg_addr !== 31'h10
            || reg_wdata !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL wr_bus: we %b re %b addr %h data %h required 1 0 10 cafef00d",
                     reg_we, reg_re, reg_addr, reg_wdata);
        end
        tick();
        tick();
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        n_cmp++;
        if (reg_we !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_done: we %b rsp_valid %b busy %b required 0 0 0",
                     reg_we, rsp_valid, busy);
        end
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ack_ignored: rsp_valid %b busy %b required 0 0",
                     rsp_valid, busy);
        end
    endtask

    task automatic test_read();
        cmd_address = 32'h8000_0004; cmd_data = 32'h0;
        cmd_read = 1'b1;
        tick();
        cmd_read = 1'b0;
        tick();
        n_cmp++;
        if (reg_re !== 1'b1 || reg_we !== 1'b0 || reg_addr !== 31'h4) begin
            n_err++;
            $display("FAIL rd_bus: re %b we %b addr %h required 1 0 4",
                     reg_re, reg_we, reg_addr);
        end
        reg_ack = 1'b1; reg_rdata = 32'h1234_5678;
        tick();
        reg_ack = 1'b0; reg_rdata = 32'hDEAD_BEEF;
        n_cmp++;
        if (reg_re !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 31'h4
            || rsp_data !== 32'h1234_5678 || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL rd_rsp: re %b v %b addr %h data %h err %b required 0 1 4 12345678 0",
                     reg_re, rsp_valid, rsp_addr, rsp_data, rsp_err);
        end
        tick();
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234_5678 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rd_hold: v %b data %h busy %b required 1 12345678 1",
                     rsp_valid, rsp_data, busy);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rd_accept: v %b busy %b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_timeout();
        cmd_address = 32'h0000_0020; cmd_data = 32'h1111_2222;
        cmd_write = 1'b1;
        tick();
        cmd_write = 1'b0;
        tick();
        repeat (8) tick();
        n_cmp++;
        if (reg_we !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL to_before: we %b v %b required 1 0", reg_we, rsp_valid);
        end
        tick();
        n_cmp++;
        if (reg_we !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1
            || rsp_data !== 32'd0 || rsp_addr !== 31'h20) begin
            n_err++;
            $display("FAIL to_rsp: we %b v %b err %b data %h addr %h required 0 1 1 0 20",
                     reg_we, rsp_valid, rsp_err, rsp_data, rsp_addr);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_address = 32'h8000_0030;
        cmd_read = 1'b1;
        tick();
        cmd_read = 1'b0;
        tick();
        repeat (8) tick();
        reg_ack = 1'b1; reg_rdata = 32'h0000_A5A5;
        tick();
        reg_ack = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0000_A5A5
            || rsp_addr !== 31'h30) begin
            n_err++;
            $display("FAIL to_ack_wins: v %b err %b data %h addr %h required 1 0 a5a5 30",
                     rsp_valid, rsp_err, rsp_data, rsp_addr);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_overflow();
        cmd_write = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_address = 32'h100 + 32'(i);
            cmd_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        cmd_write = 1'b0;
        n_cmp++;
        if (reg_we !== 1'b1 || reg_addr !== 31'h100 || reg_wdata !== 32'hA000_0000) begin
            n_err++;
            $display("FAIL ovf_issued: we %b addr %h data %h required 1 100 a0000000",
                     reg_we, reg_addr, reg_wdata);
        end
        n_cmp++;
        if (fifo_level !== 5'd4 || overflow !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_state: level %0d ovf %b busy %b required 4 1 1",
                     fifo_level, overflow, busy);
        end
        rstcmd = 1'b1;
        tick();
        rstcmd = 1'b0;
        n_cmp++;
        if (fifo_level !== 5'd0 || overflow !== 1'b0 || reg_we !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_flush: level %0d ovf %b we %b required 0 0 0",
                     fifo_level, overflow, reg_we);
        end
    endtask

    task automatic test_back_to_back();
        cmd_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_address = 32'h200 + 32'(i);
            cmd_data = 32'(i);
            tick();
        end
        cmd_write = 1'b0;
        n_cmp++;
        if (reg_we !== 1'b1 || fifo_level !== 5'd3 || reg_addr !== 31'h200) begin
            n_err++;
            $display("FAIL b2b_queued: we %b level %0d addr %h required 1 3 200",
                     reg_we, fifo_level, reg_addr);
        end
        rstcmd = 1'b1; cmd_write = 1'b1; cmd_address = 32'h300;
        tick();
        rstcmd = 1'b0; cmd_write = 1'b0;
        n_cmp++;
        if (reg_we !== 1'b0 || fifo_level !== 5'd0 || overflow !== 1'b0
            || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstcmd_flush: we %b level %0d ovf %b busy %b required 0 0 0 0",
                     reg_we, fifo_level, overflow, busy);
        end
        tick();
        tick();
        n_cmp++;
        if (reg_we !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstcmd_discard: we %b busy %b required 0 0", reg_we, busy);
        end
    endtask

    task automatic test_async_reset();
        cmd_address = 32'h8000_0040;
        cmd_read = 1'b1;
        tick();
        cmd_read = 1'b0;
        tick();
        reg_ack = 1'b1; reg_rdata = 32'h0000_0055;
        tick();
        reg_ack = 1'b0;
        cmd_address = 32'h0000_0050; cmd_write = 1'b1;
        tick();
        cmd_write = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || fifo_level !== 5'd1 || reg_we !== 1'b0) begin
            n_err++;
            $display("FAIL resp_blocks: v %b level %0d we %b required 1 1 0",
                     rsp_valid, fifo_level, reg_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, reg_we, reg_re, busy, rsp_err} !== 5'b0
            || fifo_level !== 5'd0 || rsp_data !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: flags %b level %0d data %h required 00000 0 0",
                     {rsp_valid, reg_we, reg_re, busy, rsp_err}, fifo_level, rsp_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || reg_we !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_async: busy %b we %b v %b required 0 0 0",
                     busy, reg_we, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
